// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART TX scheduler slice.
// Both requesters and the FSM use these definitions.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ALU_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } sched_state_e;

    typedef enum logic {
        REQ_RF,
        REQ_ALU
    } req_id_e;

    function automatic int bytes_per_word(input int dw, input int aw);
        return aw / dw;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester, transmitter and status signals around the scheduler.
// master drives requests and tx_busy; slave is the scheduler.
interface uart_tx_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int ALU_W  = 16
);
    logic [DATA_W-1:0] rf_data;
    logic              rf_valid;
    logic              rf_ready;
    logic [ALU_W-1:0]  alu_data;
    logic              alu_valid;
    logic              alu_ready;
    logic              tx_busy;
    logic [DATA_W-1:0] tx_p_data;
    logic              tx_data_valid;
    logic              sched_busy;
    logic              overrun;

    modport master (
        output rf_data, rf_valid, alu_data, alu_valid, tx_busy,
        input  rf_ready, alu_ready, tx_p_data, tx_data_valid,
        input  sched_busy, overrun
    );

    modport slave (
        input  rf_data, rf_valid, alu_data, alu_valid, tx_busy,
        output rf_ready, alu_ready, tx_p_data, tx_data_valid,
        output sched_busy, overrun
    );
endinterface

// File: rtl/uart_tx_scheduler_req_hold_buf.sv
// One-entry holding buffer for a requester.
// Loads on valid&&ready, frees on rel, flags a sticky overrun.
module req_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    input  logic         valid,
    input  logic         rel,
    output logic [W-1:0] q,
    output logic         full,
    output logic         ready,
    output logic         overrun
);

    assign ready = !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (valid && !full) begin
                q    <= d;
                full <= 1'b1;
            end else if (rel) begin
                full <= 1'b0;
            end
            // a push while full is dropped; held data stays intact
            if (valid && full)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin frame scheduler sharing one UART transmitter
// between register-file bytes and multi-byte ALU results.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ALU_W  = ALU_W_DEF
) (
    input logic CLK,
    input logic RST,
    uart_tx_scheduler_if.slave bus
);

    localparam int NBYTES = bytes_per_word(DATA_W, ALU_W);
    localparam int CW     = $clog2(NBYTES + 1);

    sched_state_e      state;
    req_id_e           sel;
    req_id_e           last_grant;
    req_id_e           grant;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_dec;
    int                nxt_idx;
    logic [DATA_W-1:0] txd;
    logic              txv;

    logic [DATA_W-1:0] rf_q;
    logic [ALU_W-1:0]  alu_q;
    logic              rf_full;
    logic              alu_full;
    logic              rf_ovr;
    logic              alu_ovr;
    logic              frame_end;
    logic              rel_rf;
    logic              rel_alu;

    function automatic logic [DATA_W-1:0] alu_byte(
        input logic [ALU_W-1:0] w,
        input int               idx
    );
        return w[idx*DATA_W +: DATA_W];
    endfunction

    assign frame_end = (state == WAIT_LO) && !bus.tx_busy
                       && (cnt == CW'(1));
    assign rel_rf    = frame_end && (sel == REQ_RF);
    assign rel_alu   = frame_end && (sel == REQ_ALU);

    req_hold_buf #(.W(DATA_W)) u_rf_buf (
        .clk     (CLK),
        .rst_n   (RST),
        .d       (bus.rf_data),
        .valid   (bus.rf_valid),
        .rel     (rel_rf),
        .q       (rf_q),
        .full    (rf_full),
        .ready   (bus.rf_ready),
        .overrun (rf_ovr)
    );

    req_hold_buf #(.W(ALU_W)) u_alu_buf (
        .clk     (CLK),
        .rst_n   (RST),
        .d       (bus.alu_data),
        .valid   (bus.alu_valid),
        .rel     (rel_alu),
        .q       (alu_q),
        .full    (alu_full),
        .ready   (bus.alu_ready),
        .overrun (alu_ovr)
    );

    assign bus.tx_p_data     = txd;
    assign bus.tx_data_valid = txv;
    assign bus.sched_busy    = (state != IDLE);
    assign bus.overrun       = rf_ovr | alu_ovr;

    assign cnt_dec = cnt - CW'(1);
    assign nxt_idx = NBYTES - int'(cnt_dec);

    always_comb begin
        grant = REQ_RF;
        unique case (1'b1)
            (rf_full && alu_full):
                grant = (last_grant == REQ_ALU) ? REQ_RF : REQ_ALU;
            (alu_full && !rf_full):
                grant = REQ_ALU;
            default:
                grant = REQ_RF;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            sel        <= REQ_RF;
            last_grant <= REQ_ALU;
            cnt        <= '0;
            txd        <= '0;
            txv        <= 1'b0;
        end else begin
            txv <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rf_full || alu_full) begin
                        sel        <= grant;
                        last_grant <= grant;
                        if (grant == REQ_ALU) begin
                            cnt <= CW'(NBYTES);
                            txd <= alu_byte(alu_q, 0);
                        end else begin
                            cnt <= CW'(1);
                            txd <= rf_q;
                        end
                        // withhold the pulse if the transmitter is still busy
                        txv   <= !bus.tx_busy;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (txv)
                        state <= WAIT_HI;
                    else if (!bus.tx_busy)
                        txv <= 1'b1;
                end
                WAIT_HI: begin
                    if (bus.tx_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        cnt <= cnt_dec;
                        if (cnt_dec == '0) begin
                            state <= IDLE;
                        end else begin
                            txd   <= alu_byte(alu_q, nxt_idx);
                            txv   <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
